// File: rtl/snake_body_engine.sv
// Snake game core: body segments on a cell grid, key steering with reversal lock, grow, collisions, pixel flags.
// Latency: one move per tick period; head/dir/length/step update the cycle after the move edge; pixel flags lag pos by 1 clk.
// Backpressure: none; keys are level requests, grow/restart are single-cycle pulses and are never stalled.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   speed_sel             move period = TICK_BASE >> speed_sel clocks (applied at the next wrap)
//   key_right/left/down/up level direction requests, priority right > left > down > up
//   grow, restart         single-cycle pulses: add one segment / reinitialise the game
//   pos_x, pos_y          VGA pixel position
//   head_x, head_y, dir   head cell and committed direction (00 up, 01 down, 10 left, 11 right)
//   length, step, died    active segments, move pulse, dead flag
//   head_pixel, body_pixel registered hit flags for the current pixel
module snake_body_engine #(
  parameter int MAX_LEN    = 16,
  parameter int INIT_LEN   = 3,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int COORD_W    = 6,
  parameter int CELL_SHIFT = 4,
  parameter int TICK_BASE  = 12500000,
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         speed_sel,
  input  logic               key_right,
  input  logic               key_left,
  input  logic               key_down,
  input  logic               key_up,
  input  logic               grow,
  input  logic               restart,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [1:0]         dir,
  output logic [LEN_W-1:0]   length,
  output logic               step,
  output logic               died,
  output logic               head_pixel,
  output logic               body_pixel
);

  localparam int CNT_W = $clog2(TICK_BASE + 1);
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;
  state_t state_q, state_d;

  logic [COORD_W-1:0] seg_x [MAX_LEN];
  logic [COORD_W-1:0] seg_y [MAX_LEN];
  logic [1:0]         dir_q, next_dir_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   tick_q, period_q, period_new;
  logic               grow_pend_q, step_q, head_pix_q, body_pix_q;

  logic               key_any, key_ok, wrap, growing, wall, self_hit, do_move;
  logic [1:0]         key_dir, lock_ref;
  logic [COORD_W-1:0] nh_x, nh_y;
  logic [9:0]         cell_x, cell_y;
  logic               head_pix_d, body_pix_d;
  int                 hit_lim;

  // Period of zero (large speed_sel, small base) would never wrap; clamp to one clock.
  always_comb begin
    period_new = CNT_W'(TICK_BASE >> speed_sel);
    if (period_new == '0) period_new = CNT_W'(1);
  end

  assign wrap = (state_q == S_RUN) && (tick_q == period_q - CNT_W'(1));

  // On the wrap cycle next_dir becomes the committed dir, so the lock must look at it,
  // otherwise a key arriving that cycle could reverse the freshly committed heading.
  always_comb begin
    key_any  = key_right | key_left | key_down | key_up;
    key_dir  = key_right ? DIR_RIGHT : key_left ? DIR_LEFT : key_down ? DIR_DOWN : DIR_UP;
    lock_ref = wrap ? next_dir_q : dir_q;
    key_ok   = key_any && (key_dir != (lock_ref ^ 2'b01));
  end

  // Candidate head; wall is detected before the coordinate would leave the grid.
  always_comb begin
    nh_x = seg_x[0];
    nh_y = seg_y[0];
    wall = 1'b0;
    case (next_dir_q)
      DIR_UP:    begin wall = (seg_y[0] == '0);                     nh_y = seg_y[0] - COORD_W'(1); end
      DIR_DOWN:  begin wall = (seg_y[0] == COORD_W'(GRID_H - 1));   nh_y = seg_y[0] + COORD_W'(1); end
      DIR_LEFT:  begin wall = (seg_x[0] == '0);                     nh_x = seg_x[0] - COORD_W'(1); end
      default:   begin wall = (seg_x[0] == COORD_W'(GRID_W - 1));   nh_x = seg_x[0] + COORD_W'(1); end
    endcase
  end

  // The tail cell vacates on a plain move, so it only counts as an obstacle when growing.
  // Growth at MAX_LEN does not happen, so the tail still vacates there.
  always_comb begin
    growing  = grow_pend_q && (len_q < LEN_W'(MAX_LEN));
    hit_lim  = int'(len_q) - 2 + (growing ? 1 : 0);
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (i <= hit_lim && seg_x[i] == nh_x && seg_y[i] == nh_y) self_hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    do_move = 1'b0;
    case (state_q)
      S_IDLE: if (key_any) state_d = S_RUN;
      S_RUN: begin
        if (wrap) begin
          if (wall || self_hit) state_d = S_DEAD;
          else                  do_move = 1'b1;
        end
      end
      default: state_d = state_q;  // DEAD leaves only through restart
    endcase
  end

  always_comb begin
    cell_x     = pos_x >> CELL_SHIFT;
    cell_y     = pos_y >> CELL_SHIFT;
    head_pix_d = (cell_x == 10'(seg_x[0])) && (cell_y == 10'(seg_y[0]));
    body_pix_d = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (i < int'(len_q) && cell_x == 10'(seg_x[i]) && cell_y == 10'(seg_y[i])) body_pix_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      state_q <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= COORD_W'(GRID_W / 2 - ((i < INIT_LEN) ? i : INIT_LEN - 1));
        seg_y[i] <= COORD_W'(GRID_H / 2);
      end
      dir_q       <= DIR_RIGHT;
      next_dir_q  <= DIR_RIGHT;
      len_q       <= LEN_W'(INIT_LEN);
      tick_q      <= '0;
      period_q    <= period_new;
      grow_pend_q <= 1'b0;
      step_q      <= 1'b0;
      head_pix_q  <= 1'b0;
      body_pix_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= do_move;
      head_pix_q <= head_pix_d;
      body_pix_q <= body_pix_d;

      if (state_q != S_RUN || wrap) period_q <= period_new;
      if (state_q == S_RUN) tick_q <= wrap ? '0 : tick_q + CNT_W'(1);

      if (state_q != S_DEAD && key_ok) next_dir_q <= key_dir;

      if (do_move)                          grow_pend_q <= grow;
      else if (grow && state_q != S_DEAD)   grow_pend_q <= 1'b1;

      if (do_move) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x[i] <= seg_x[i-1];
          seg_y[i] <= seg_y[i-1];
        end
        seg_x[0] <= nh_x;
        seg_y[0] <= nh_y;
        dir_q    <= next_dir_q;
        if (growing) len_q <= len_q + LEN_W'(1);
      end
    end
  end

  assign head_x     = seg_x[0];
  assign head_y     = seg_y[0];
  assign dir        = dir_q;
  assign length     = len_q;
  assign step       = step_q;
  assign died       = (state_q == S_DEAD);
  assign head_pixel = head_pix_q;
  assign body_pixel = body_pix_q;

endmodule

// File: tb/tb_snake_body_engine.sv
module tb_snake_body_engine;

  logic       clk = 1'b0;
  logic       rst_n, grow, restart;
  logic       key_right, key_left, key_down, key_up;
  logic [2:0] speed_sel;
  logic [9:0] pos_x, pos_y;
  logic [5:0] head_x, head_y;
  logic [1:0] dir;
  logic [4:0] length;
  logic       step, died, head_pixel, body_pixel;

  snake_body_engine #(.TICK_BASE(8)) dut (
    .clk(clk), .rst_n(rst_n), .speed_sel(speed_sel),
    .key_right(key_right), .key_left(key_left), .key_down(key_down), .key_up(key_up),
    .grow(grow), .restart(restart), .pos_x(pos_x), .pos_y(pos_y),
    .head_x(head_x), .head_y(head_y), .dir(dir), .length(length),
    .step(step), .died(died), .head_pixel(head_pixel), .body_pixel(body_pixel)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_death;
    int hx, hy, d, len;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic died_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit dth, input int x, input int y, input int d, input int l);
    exp_t e;
    e.is_death = dth; e.hx = x; e.hy = y; e.d = d; e.len = l;
    return e;
  endfunction

  // Monitor: every step pulse or rising died is an output event matched against the scoreboard.
  always @(negedge clk) begin
    if (step === 1'b1 || (died === 1'b1 && died_prev !== 1'b1)) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {31'd0, died}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_kind", {31'd0, died}, {31'd0, e.is_death});
        chk("event_step", {31'd0, step}, {31'd0, !e.is_death});
        chk("head_x", head_x, e.hx);
        chk("head_y", head_y, e.hy);
        chk("dir", dir, e.d);
        chk("length", length, e.len);
      end
    end
    died_prev = died;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One move period (8 clks): optional key/grow pulse in the first cycle, expected event queued.
  task automatic period(input logic [3:0] k, input logic g, input exp_t e);
    {key_right, key_left, key_down, key_up} = k;
    grow = g;
    q.push_back(e);
    tick(1);
    {key_right, key_left, key_down, key_up} = 4'b0;
    grow = 1'b0;
    tick(7);
  endtask

  task automatic pulse_keys(input logic [3:0] k);
    {key_right, key_left, key_down, key_up} = k;
    tick(1);
    {key_right, key_left, key_down, key_up} = 4'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    chk("rst_head_x", head_x, 20);
    chk("rst_head_y", head_y, 15);
    chk("rst_dir", dir, 3);
    chk("rst_length", length, 3);
    chk("rst_died", {31'd0, died}, 0);
  endtask

  task automatic pix(input int cx, input int cy, input logic eh, input logic eb, input string name);
    pos_x = 10'(cx * 16 + 5);
    pos_y = 10'(cy * 16 + 9);
    tick(1);
    chk({name, "_head"}, {31'd0, head_pixel}, {31'd0, eh});
    chk({name, "_body"}, {31'd0, body_pixel}, {31'd0, eb});
  endtask

  localparam logic [3:0] K_NONE = 4'b0000, K_R = 4'b1000, K_L = 4'b0100, K_D = 4'b0010, K_U = 4'b0001;

  initial begin
    rst_n = 1'b0; grow = 1'b0; restart = 1'b0; speed_sel = 3'd0;
    {key_right, key_left, key_down, key_up} = 4'b0;
    pos_x = '0; pos_y = '0;
    tick(3);
    rst_n = 1'b1;
    chk("reset_head_x", head_x, 20);
    chk("reset_head_y", head_y, 15);
    chk("reset_dir", dir, 3);
    chk("reset_length", length, 3);
    chk("reset_step", {31'd0, step}, 0);
    chk("reset_died", {31'd0, died}, 0);
    chk("reset_head_pixel", {31'd0, head_pixel}, 0);
    chk("reset_body_pixel", {31'd0, body_pixel}, 0);

    // Pixel latency: new pos is not reflected until the next edge.
    pos_x = 10'd325; pos_y = 10'd247;
    @(negedge clk);
    chk("pix_latency_before", {31'd0, head_pixel}, 0);
    tick(1);
    chk("pix_head_20_15", {31'd0, head_pixel}, 1);
    pix(19, 15, 1'b0, 1'b1, "pix_19_15");
    pix(18, 15, 1'b0, 1'b1, "pix_18_15");
    pix(17, 15, 1'b0, 1'b0, "pix_17_15");

    // Start, first move, reversal lock, turn.
    pulse_keys(K_R);
    period(K_NONE, 1'b0, mk(0, 21, 15, 3, 3));
    period(K_L,    1'b0, mk(0, 22, 15, 3, 3));
    period(K_U,    1'b0, mk(0, 22, 14, 0, 3));

    // Left then down in one period: down is the reverse of committed up, so left stands.
    key_left = 1'b1; tick(1); key_left = 1'b0;
    key_down = 1'b1; tick(1); key_down = 1'b0;
    q.push_back(mk(0, 21, 14, 2, 3));
    tick(6);

    // Three grow pulses within one period add a single segment.
    q.push_back(mk(0, 20, 14, 2, 4));
    for (int i = 0; i < 3; i++) begin
      grow = 1'b1; tick(1); grow = 1'b0; tick(1);
    end
    tick(2);

    // Grow every period up to and past MAX_LEN.
    for (int k = 1; k <= 13; k++) begin
      period(K_NONE, 1'b1, mk(0, 20 - k, 14, 2, (4 + k > 16) ? 16 : 4 + k));
    end

    // Wall: 19 moves right to the last column, the 20th kills without stepping.
    do_restart();
    pulse_keys(K_R);
    for (int k = 1; k <= 19; k++) period(K_NONE, 1'b0, mk(0, 20 + k, 15, 3, 3));
    period(K_NONE, 1'b0, mk(1, 39, 15, 3, 3));
    chk("wall_died", {31'd0, died}, 1);
    pulse_keys(K_U);
    tick(20);
    chk("dead_keys_ignored", {31'd0, died}, 1);
    chk("dead_frozen_x", head_x, 39);
    chk("dead_step_low", {31'd0, step}, 0);
    pix(39, 15, 1'b1, 1'b0, "dead_pix_39");
    pix(38, 15, 1'b0, 1'b1, "dead_pix_38");
    pix(36, 15, 1'b0, 1'b0, "dead_pix_36");

    // Length 4: head moves into the cell the tail vacates, no collision.
    do_restart();
    grow = 1'b1; tick(1); grow = 1'b0;
    pulse_keys(K_R);
    period(K_NONE, 1'b0, mk(0, 21, 15, 3, 4));
    period(K_U,    1'b0, mk(0, 21, 14, 0, 4));
    period(K_L,    1'b0, mk(0, 20, 14, 2, 4));
    period(K_D,    1'b0, mk(0, 20, 15, 1, 4));
    chk("tail_chase_alive", {31'd0, died}, 0);

    // Length 5: up, left, down runs the head into its own body.
    do_restart();
    grow = 1'b1; tick(1); grow = 1'b0;
    pulse_keys(K_R);
    period(K_NONE, 1'b0, mk(0, 21, 15, 3, 4));
    period(K_NONE, 1'b1, mk(0, 22, 15, 3, 5));
    period(K_U,    1'b0, mk(0, 22, 14, 0, 5));
    period(K_L,    1'b0, mk(0, 21, 14, 2, 5));
    period(K_D,    1'b0, mk(1, 21, 14, 2, 5));
    chk("self_hit_died", {31'd0, died}, 1);
    do_restart();
    tick(10);
    chk("restart_idle_no_step", {31'd0, step}, 0);
    chk("restart_idle_head_x", head_x, 20);

    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
